// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction prefetch queue
package fetch_queue_pkg;

    localparam int WORD = 16;
    localparam logic [WORD-1:0] RESETPC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [WORD-1:0] word;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - DEPTH-entry {pc, word} FIFO with push/pop/flush and occupancy count
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        push_i,
    input  fq_entry_t   push_data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output fq_entry_t   head_o,
    output logic [AW:0] count_o
);

    fq_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_pop;

    assign do_pop = pop_i && (count_q != '0);

    // Flush overrides any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch: single-outstanding memory fetch into a small queue
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH   = 4,
    parameter logic [WORD-1:0] RESETPC = RESETPC_DEFAULT,
    localparam int             AW      = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            mem_req_o,
    output logic [WORD-1:0] mem_addr_o,
    input  logic            mem_ready_i,
    input  logic [WORD-1:0] mem_data_i,
    input  logic            redirect_i,
    input  logic [WORD-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [WORD-1:0] ir_o,
    output logic [WORD-1:0] ir_pc_o,
    output logic            ir_valid_o,
    input  logic            ir_take_i,
    output logic [AW:0]     count_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] req_addr_q, req_addr_d;
    logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
    logic            push, pop;
    logic [AW:0]     count_next;
    fq_entry_t       head;

    assign pop        = ir_take_i && ir_valid_o && !redirect_i;
    assign count_next = count_o - {{AW{1'b0}}, pop};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            req_addr_q <= RESETPC;
            fetch_pc_q <= RESETPC;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Issue checks use the post-pop count so a consumed slot can be refilled in the same cycle.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    req_addr_d = redirect_pc_i;
                    fetch_pc_d = redirect_pc_i + 16'd1;
                    state_d    = ST_BUSY;
                end else if (!halt_i && count_next < FULL) begin
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (redirect_i) begin
                    if (mem_ready_i) begin
                        req_addr_d = redirect_pc_i;
                        fetch_pc_d = redirect_pc_i + 16'd1;
                    end else begin
                        fetch_pc_d = redirect_pc_i;
                        state_d    = ST_DROP;
                    end
                end else if (mem_ready_i) begin
                    push = 1'b1;
                    if (!halt_i && count_next < LAST) begin
                        req_addr_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (mem_ready_i) begin
                    req_addr_d = redirect_i ? redirect_pc_i : fetch_pc_q;
                    fetch_pc_d = (redirect_i ? redirect_pc_i : fetch_pc_q) + 16'd1;
                    state_d    = ST_BUSY;
                end else if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = (state_q == ST_BUSY) || (state_q == ST_DROP);
        mem_addr_o = req_addr_q;
        ir_o       = head.word;
        ir_pc_o    = head.pc;
        ir_valid_o = (count_o != '0);
    end

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i ('{pc: req_addr_q, word: mem_data_i}),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .count_o     (count_o)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a variable-wait memory model
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_ready, redirect, halt, ir_valid, ir_take;
    logic [15:0] mem_addr, mem_data, redirect_pc, ir, ir_pc;
    logic [2:0]  count;

    logic        mem_req2, ir_valid2;
    logic [15:0] mem_addr2, ir2, ir_pc2;
    logic [2:0]  count2;
    logic [15:0] mem_data2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb [$];
    logic [15:0] exp_pc;
    logic        drop_pending, hold_pending;
    logic [15:0] hold_addr;
    int          mem_wait, wait_cnt, acc_cnt, idx2;
    logic [15:0] wrap_exp [4];

    always #5 clk = ~clk;

    assign mem_data2 = mem_addr2 ^ 16'hA5A5;

    fetch_queue #(.DEPTH(4), .RESETPC(16'h0000)) dut (
        .clk_i(clk), .reset_i(rst_n), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ready_i(mem_ready), .mem_data_i(mem_data), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .halt_i(halt), .ir_o(ir), .ir_pc_o(ir_pc),
        .ir_valid_o(ir_valid), .ir_take_i(ir_take), .count_o(count)
    );

    fetch_queue #(.DEPTH(4), .RESETPC(16'hFFFE)) dut2 (
        .clk_i(clk), .reset_i(rst_n), .mem_req_o(mem_req2), .mem_addr_o(mem_addr2),
        .mem_ready_i(1'b1), .mem_data_i(mem_data2), .redirect_i(1'b0),
        .redirect_pc_i(16'h0000), .halt_i(1'b0), .ir_o(ir2), .ir_pc_o(ir_pc2),
        .ir_valid_o(ir_valid2), .ir_take_i(1'b0), .count_o(count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc       = 16'h0000;
        drop_pending = 1'b0;
        hold_pending = 1'b0;
        wait_cnt     = 0;
        acc_cnt      = 0;
    endtask

    // One clock: memory answers at the negedge, scoreboard books the coming posedge.
    task automatic step();
        logic [31:0] front;
        @(negedge clk);
        mem_ready = mem_req && (wait_cnt >= mem_wait);
        mem_data  = mem_addr ^ 16'hA5A5;
        if (rst_n) begin
            if (hold_pending) check_eq("addr_hold", {16'h0, mem_addr}, {16'h0, hold_addr});
            check_eq("count", {29'h0, count}, sb.size());
            check_eq("ir_valid", {31'h0, ir_valid}, {31'h0, sb.size() != 0});
            if (mem_req2 && idx2 < 4) begin
                check_eq("wrap_addr", {16'h0, mem_addr2}, {16'h0, wrap_exp[idx2]});
                idx2++;
            end
            if (redirect) begin
                sb.delete();
                exp_pc       = redirect_pc;
                drop_pending = mem_req && !mem_ready;
            end else begin
                if (ir_take && ir_valid && sb.size() != 0) begin
                    front = sb.pop_front();
                    check_eq("ir_pc", {16'h0, ir_pc}, {16'h0, front[31:16]});
                    check_eq("ir", {16'h0, ir}, {16'h0, front[15:0]});
                end
                if (mem_req && mem_ready) begin
                    if (drop_pending) begin
                        drop_pending = 1'b0;
                    end else begin
                        check_eq("fetch_addr", {16'h0, mem_addr}, {16'h0, exp_pc});
                        sb.push_back({exp_pc, exp_pc ^ 16'hA5A5});
                        exp_pc = exp_pc + 16'd1;
                        acc_cnt++;
                    end
                end
            end
            hold_pending = mem_req && !mem_ready;
            hold_addr    = mem_addr;
            if (mem_req && mem_ready) wait_cnt = 0;
            else if (mem_req)         wait_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;
        idx2 = 0;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0; ir_take = 1'b0;
        mem_ready = 1'b0; mem_data = 16'h0; mem_wait = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check_eq("rst_ir_valid", {31'h0, ir_valid}, 32'd0);
        check_eq("rst_ir", {16'h0, ir}, 32'd0);
        check_eq("rst_ir_pc", {16'h0, ir_pc}, 32'd0);
        check_eq("rst_count", {29'h0, count}, 32'd0);
        rst_n = 1'b1;

        // Fill from reset with zero-wait memory.
        run(8);
        check_eq("t1_count", {29'h0, count}, 32'd4);
        check_eq("t1_mem_req", {31'h0, mem_req}, 32'd0);
        check_eq("t1_ir", {16'h0, ir}, 32'h0000A5A5);
        check_eq("t1_ir_pc", {16'h0, ir_pc}, 32'd0);
        check_eq("t5_wrap_seen", idx2, 32'd4);

        // Single pop from full refills with exactly one request.
        ir_take = 1'b1;
        run(1);
        ir_take = 1'b0;
        run(3);
        check_eq("t2_count", {29'h0, count}, 32'd4);
        check_eq("t2_one_req", acc_cnt, 32'd5);
        check_eq("t2_idle", {31'h0, mem_req}, 32'd0);
        ir_take = 1'b1;
        run(10);

        // Drain under halt, then redirect during a waited request.
        halt = 1'b1;
        run(8);
        check_eq("t6_halt_drain", {29'h0, count}, 32'd0);
        halt = 1'b0; ir_take = 1'b0; mem_wait = 3;
        run(1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        run(1);
        redirect = 1'b0;
        check_eq("t3_flush", {29'h0, count}, 32'd0);
        check_eq("t3_req_held", {31'h0, mem_req}, 32'd1);
        run(12);
        check_eq("t3_valid", {31'h0, ir_valid}, 32'd1);
        check_eq("t3_ir_pc", {16'h0, ir_pc}, 32'h00000100);

        // Redirect coinciding with mem_ready and ir_take.
        mem_wait = 0; ir_take = 1'b1;
        run(6);
        check_eq("t4_busy", {31'h0, mem_req}, 32'd1);
        redirect = 1'b1; redirect_pc = 16'h0200;
        run(1);
        redirect = 1'b0;
        check_eq("t4_count", {29'h0, count}, 32'd0);
        check_eq("t4_addr", {16'h0, mem_addr}, 32'h00000200);
        run(6);

        // Async reset mid-BUSY with three entries queued.
        ir_take = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0300;
        run(1);
        redirect = 1'b0;
        run(3);
        check_eq("t6_pre_count", {29'h0, count}, 32'd3);
        check_eq("t6_pre_req", {31'h0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_req", {31'h0, mem_req}, 32'd0);
        check_eq("t6_async_valid", {31'h0, ir_valid}, 32'd0);
        check_eq("t6_async_count", {29'h0, count}, 32'd0);
        model_reset();
        halt = 1'b1;
        run(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t6_halt_noreq", {31'h0, mem_req}, 32'd0);
        end
        halt = 1'b0;
        run(4);
        check_eq("t6_restart_valid", {31'h0, ir_valid}, 32'd1);
        check_eq("t6_restart_pc", {16'h0, ir_pc}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the decode/IF stage of the 16-bit float pipeline.
- Fetches instruction words from instruction memory through a req/ready handshake with at most one request outstanding.
- Buffers each fetched word with its PC in a small FIFO and presents the head word to decode.
- Flushes on a taken jz redirect and stops fetching on halt.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, at least 2.
- RESETPC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request valid.
- mem_addr  out  16  fetch address; stable while mem_req=1 until accepted.
- mem_ready  in  1  memory returns mem_data for mem_addr this cycle; sampled only when mem_req=1.
- mem_data  in  16  instruction word.
- redirect  in  1  taken jz: flush and refetch from redirect_pc.
- redirect_pc  in  16  new fetch address.
- halt  in  1  level; when 1, no new requests are issued.
- ir  out  16  head instruction word; 16'h0000 when empty.
- ir_pc  out  16  PC of head word; 16'h0000 when empty.
- ir_valid  out  1  queue non-empty.
- ir_take  in  1  decode consumes head this cycle; ignored when ir_valid=0.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, async): state IDLE, count=0, pointers=0, req_addr=RESETPC, fetch_pc=RESETPC, mem_req=0, ir_valid=0, ir=0, ir_pc=0.
- mem_req is 1 exactly in BUSY and DROP. mem_addr=req_addr.
- IDLE:
  - if redirect: req_addr<=redirect_pc, fetch_pc<=redirect_pc+1, go BUSY.
  - else if !halt and count_next<DEPTH: req_addr<=fetch_pc, fetch_pc<=fetch_pc+1, go BUSY.
- BUSY:
  - mem_ready and no redirect: push {req_addr, mem_data}. If !halt and room remains after this cycle's push/pop, issue the next request immediately (req_addr<=fetch_pc, fetch_pc+1, stay BUSY); otherwise go IDLE. Sustained throughput is 1 word/cycle.
  - redirect and mem_ready in the same cycle: discard the response, flush, req_addr<=redirect_pc, fetch_pc<=redirect_pc+1, stay BUSY.
  - redirect without mem_ready: flush, fetch_pc<=redirect_pc, go DROP. req_addr is held because the address must stay stable.
- DROP:
  - on mem_ready: discard the data, req_addr<=fetch_pc, fetch_pc+1, go BUSY.
  - a further redirect in DROP updates fetch_pc only.
- Flush: count<=0 and pointers reset. A same-cycle ir_take is ignored and a same-cycle push is suppressed; redirect wins over all.
- Push and pop in the same cycle: both happen and count is unchanged. Allowed even when full, because the full check uses count_next = count - pop.
- Latency: word is visible on ir the cycle after mem_ready; the first valid ir is 2 cycles after reset release with zero-wait memory.
- Arithmetic: PC increments mod 2^16 (16'hFFFF -> 16'h0000). FIFO pointers wrap mod DEPTH.
- Halt: an outstanding request still completes and is pushed. The queue keeps draining to decode. Fetch resumes from fetch_pc when halt drops.
- Never more than DEPTH entries. count+outstanding may exceed DEPTH only by a pop-credited issue that is guaranteed room on return.

Decomposition:
- Shared package: WORD width (16), fetch state encodings (IDLE/BUSY/DROP), RESETPC default.
- One natural sub-module: fq_fifo, a DEPTH-entry {pc, word} storage with push/pop/flush, pointers, and count.
- The FSM, PC logic and handshake stay in fetch_queue.

Test Plan:
1. Release reset, mem_ready tied 1, memory word = address XOR 16'hA5A5, ir_take=0 -> requests addresses 0,1,2,3; count reaches 4; mem_req=0 after that; ir=16'hA5A5, ir_pc=0.
2. Full queue, then ir_take=1 for 1 cycle -> exactly one new request (address 4) is issued and the queue returns to count=4. With ir_take held 1: one word/cycle, ir_pc increments by 1 each cycle.
3. Memory with 3-cycle wait; redirect to 16'h0100 in the first wait cycle -> queue empties, mem_addr holds the old address until mem_ready, that data is never pushed, next request is 16'h0100, and the first ir_pc is 16'h0100.
4. Redirect and mem_ready in the same cycle with ir_take=1 -> count=0 next cycle and mem_addr=redirect_pc.
5. RESETPC=16'hFFFE, zero-wait memory -> fetch order FFFE, FFFF, 0000, 0001.
6. Assert reset mid-BUSY with count=3 -> mem_req, ir_valid and count go to 0 immediately (async). After release, fetch restarts at RESETPC. halt=1 at release -> no request until halt=0.
